// File: rtl/pe_issue_unit.sv
// pe_issue_unit: steps through a small instruction memory. It fetches vector
// operands, issues commands to a processing element (PE) over a valid/ready
// handshake, and gathers PE results into a result memory for readback.
// Opcodes: NOOP 0, FETCH_A 1, FETCH_B 2, ADD..STORE_RESULT 3..9 (PE commands),
// STOP 10, LOOP 11. Codes 12-15 behave as NOOP.
// Optional feature: define PE_ISSUE_LOOP_EN to enable the single-level LOOP
// instruction. Without it, LOOP behaves as NOOP.
module pe_issue_unit #(
    parameter int LANES         = 4,
    parameter int DATA_LEN      = 32,
    parameter int INST_LEN      = 16,
    parameter int OPCODE_LEN    = 4,
    parameter int PE_OPCODE_LEN = 3,
    parameter int IMEM_DEPTH    = 64,
    parameter int DMEM_DEPTH    = 64
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                prog_we,
    input  logic [1:0]                          prog_sel,
    input  logic [$clog2((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH)-1:0] prog_addr,
    input  logic [DATA_LEN*LANES-1:0]           prog_wdata,
    output logic                                pe_valid,
    input  logic                                pe_ready,
    output logic [PE_OPCODE_LEN-1:0]            pe_opcode,
    output logic [DATA_LEN*LANES-1:0]           data_a,
    output logic [DATA_LEN*LANES-1:0]           data_b,
    input  logic                                pe_stage_1_valid,
    input  logic [DATA_LEN*LANES-1:0]           pe_stage_1_output,
    input  logic                                pe_stage_2_valid,
    input  logic [DATA_LEN-1:0]                 pe_stage_2_output,
    input  logic [$clog2(DMEM_DEPTH)-1:0]       res_raddr,
    output logic [DATA_LEN*LANES-1:0]           res_rdata,
    output logic                                busy,
    output logic                                done
);
    localparam int PC_W  = $clog2(IMEM_DEPTH);
    localparam int DA_W  = $clog2(DMEM_DEPTH);
    localparam int VEC_W = DATA_LEN * LANES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [OPCODE_LEN-1:0] OP_FETCH_A      = OPCODE_LEN'(1);
    localparam logic [OPCODE_LEN-1:0] OP_FETCH_B      = OPCODE_LEN'(2);
    localparam logic [OPCODE_LEN-1:0] OP_ADD          = OPCODE_LEN'(3);
    localparam logic [OPCODE_LEN-1:0] OP_STORE_RESULT = OPCODE_LEN'(9);
    localparam logic [OPCODE_LEN-1:0] OP_STOP         = OPCODE_LEN'(10);

    logic [INST_LEN-1:0] imem [IMEM_DEPTH];
    logic [VEC_W-1:0]    amem [DMEM_DEPTH];
    logic [VEC_W-1:0]    bmem [DMEM_DEPTH];
    logic [VEC_W-1:0]    rmem [DMEM_DEPTH];

    logic [1:0]            state;
    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       pc_plus1;
    logic [PC_W-1:0]       pc_next;
    logic [INST_LEN-1:0]   inst;
    logic [OPCODE_LEN-1:0] opcode;
    logic [DA_W-1:0]       op_addr;
    logic [VEC_W-1:0]      res_reg;
    logic                  run;
    logic                  is_pe;
    logic                  fire;
    logic                  advance;
    logic                  unused_inst;

    assign inst        = imem[pc];
    assign opcode      = inst[OPCODE_LEN-1:0];
    assign op_addr     = inst[OPCODE_LEN+DA_W-1:OPCODE_LEN];
    assign unused_inst = ^inst;

    assign run     = (state == S_RUN);
    assign is_pe   = (opcode >= OP_ADD) && (opcode <= OP_STORE_RESULT);
    assign fire    = pe_valid && pe_ready;
    assign advance = run && (opcode != OP_STOP) && (!is_pe || pe_ready);

    assign pe_valid  = run && is_pe;
    assign pe_opcode = pe_valid ? PE_OPCODE_LEN'(opcode - OPCODE_LEN'(2)) : '0;
    assign busy      = run;
    assign done      = (state == S_HALT);

    assign pc_plus1 = (32'(pc) == IMEM_DEPTH - 1) ? '0 : pc + PC_W'(1);

`ifdef PE_ISSUE_LOOP_EN
    localparam logic [OPCODE_LEN-1:0] OP_LOOP = OPCODE_LEN'(11);

    logic [3:0]      loop_ctr;
    logic [3:0]      loop_count;
    logic [PC_W-1:0] jump_target;
    logic            loop_jump;

    assign loop_count  = inst[INST_LEN-1:INST_LEN-4];
    assign jump_target = PC_W'(op_addr);
    assign loop_jump   = (opcode == OP_LOOP) &&
                         (((loop_ctr == 4'd0) && (loop_count != 4'd0)) || (loop_ctr > 4'd1));
    assign pc_next     = loop_jump ? jump_target : pc_plus1;

    // Single loop counter: loaded on first LOOP pass, counted down on each repeat
    always_ff @(posedge clk) begin
        if (!rstn) begin
            loop_ctr <= 4'd0;
        end else if (!run && start) begin
            loop_ctr <= 4'd0;
        end else if (run && (opcode == OP_LOOP)) begin
            if (loop_ctr == 4'd0) begin
                loop_ctr <= loop_count;
            end else begin
                loop_ctr <= loop_ctr - 4'd1;
            end
        end
    end
`else
    assign pc_next = pc_plus1;
`endif

    // Sequencer: IDLE/HALT wait for start, RUN steps pc until STOP
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= '0;
                    end
                end
                S_RUN: begin
                    if (opcode == OP_STOP) begin
                        state <= S_HALT;
                    end else if (advance) begin
                        pc <= pc_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand registers are loaded by FETCH_A/FETCH_B on the same edge that advances pc
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_a <= '0;
            data_b <= '0;
        end else if (run) begin
            if (opcode == OP_FETCH_A) data_a <= amem[op_addr];
            if (opcode == OP_FETCH_B) data_b <= bmem[op_addr];
        end
    end

    // Result collector: a full vector from stage 1 has priority over a stage-2 scalar shift-in
    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_reg <= '0;
        end else if (pe_stage_1_valid) begin
            res_reg <= pe_stage_1_output;
        end else if (pe_stage_2_valid) begin
            res_reg <= {res_reg[VEC_W-DATA_LEN-1:0], pe_stage_2_output};
        end
    end

    // Program/data loading is only accepted while the sequencer is not running
    always_ff @(posedge clk) begin
        if (prog_we && !run) begin
            case (prog_sel)
                2'd0: if (32'(prog_addr) < IMEM_DEPTH) imem[prog_addr[PC_W-1:0]] <= prog_wdata[INST_LEN-1:0];
                2'd1: if (32'(prog_addr) < DMEM_DEPTH) amem[prog_addr[DA_W-1:0]] <= prog_wdata;
                2'd2: if (32'(prog_addr) < DMEM_DEPTH) bmem[prog_addr[DA_W-1:0]] <= prog_wdata;
                default: ;
            endcase
        end
    end

    // STORE_RESULT writes the collector value as it stood before this edge
    always_ff @(posedge clk) begin
        if (rstn && fire && (opcode == OP_STORE_RESULT)) begin
            rmem[op_addr] <= res_reg;
        end
    end

    // Registered readback port; deliberately not reset so memory stays visible
    always_ff @(posedge clk) begin
        res_rdata <= rmem[res_raddr];
    end

endmodule

// File: tb/tb_pe_issue_unit.sv
// tb_pe_issue_unit: directed self-checking bench for pe_issue_unit.
// Honours PE_ISSUE_LOOP_EN so the expected LOOP behaviour matches the build.
module tb_pe_issue_unit;
    localparam int VEC_W = 128;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic             prog_we;
    logic [1:0]       prog_sel;
    logic [5:0]       prog_addr;
    logic [VEC_W-1:0] prog_wdata;
    logic             pe_valid;
    logic             pe_ready;
    logic [2:0]       pe_opcode;
    logic [VEC_W-1:0] data_a;
    logic [VEC_W-1:0] data_b;
    logic             pe_stage_1_valid;
    logic [VEC_W-1:0] pe_stage_1_output;
    logic             pe_stage_2_valid;
    logic [31:0]      pe_stage_2_output;
    logic [5:0]       res_raddr;
    logic [VEC_W-1:0] res_rdata;
    logic             busy;
    logic             done;

    int checkCount    = 0;
    int errorCount    = 0;
    int addHandshakes = 0;
    int expectedAdds;

    always #5 clk = ~clk;

    pe_issue_unit dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .prog_we(prog_we),
        .prog_sel(prog_sel),
        .prog_addr(prog_addr),
        .prog_wdata(prog_wdata),
        .pe_valid(pe_valid),
        .pe_ready(pe_ready),
        .pe_opcode(pe_opcode),
        .data_a(data_a),
        .data_b(data_b),
        .pe_stage_1_valid(pe_stage_1_valid),
        .pe_stage_1_output(pe_stage_1_output),
        .pe_stage_2_valid(pe_stage_2_valid),
        .pe_stage_2_output(pe_stage_2_output),
        .res_raddr(res_raddr),
        .res_rdata(res_rdata),
        .busy(busy),
        .done(done)
    );

    // Count ADD handshakes mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        if (pe_valid && pe_ready && (pe_opcode == 3'd1)) addHandshakes++;
    end

    task automatic checkOutput(input string tag, input logic [VEC_W-1:0] actual,
                               input logic [VEC_W-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [5:0] addr,
                                 input logic [VEC_W-1:0] data);
        prog_we    = 1'b1;
        prog_sel   = sel;
        prog_addr  = addr;
        prog_wdata = data;
        tick();
        prog_we    = 1'b0;
    endtask

    function automatic logic [VEC_W-1:0] mkInst(input logic [3:0] op, input logic [5:0] addr,
                                                 input logic [3:0] cnt);
        logic [15:0] word;
        word = {cnt, 2'b00, addr, op};
        return {112'd0, word};
    endfunction

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; prog_we = 1'b0; prog_sel = 2'd0; prog_addr = '0;
        prog_wdata = '0; pe_ready = 1'b0; pe_stage_1_valid = 1'b0; pe_stage_1_output = '0;
        pe_stage_2_valid = 1'b0; pe_stage_2_output = '0; res_raddr = '0;
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", pe_valid, 0);
        checkOutput("rst_opcode", pe_opcode, 0);
        checkOutput("rst_data_a", data_a, 0);
        checkOutput("rst_data_b", data_b, 0);
        rstn = 1'b1;

        // Basic program: fetch both operands, ADD, store to result[5], stop
        applyStimulus(2'd1, 6'd0, {4{32'd1}});
        applyStimulus(2'd2, 6'd0, {4{32'd2}});
        applyStimulus(2'd0, 6'd0, mkInst(4'd1, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd1, mkInst(4'd2, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd2, mkInst(4'd3, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd3, mkInst(4'd9, 6'd5, 4'd0));
        applyStimulus(2'd0, 6'd4, mkInst(4'd10, 6'd0, 4'd0));
        pe_ready = 1'b1;
        pulseStart();
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_fetch_no_valid", pe_valid, 0);
        tick();
        checkOutput("t1_data_a", data_a, {4{32'd1}});
        tick();
        checkOutput("t1_data_b", data_b, {4{32'd2}});
        checkOutput("t1_add_valid", pe_valid, 1);
        checkOutput("t1_add_opcode", pe_opcode, 1);
        pe_stage_1_valid  = 1'b1;
        pe_stage_1_output = {4{32'd3}};
        tick();
        pe_stage_1_valid  = 1'b0;
        checkOutput("t1_store_opcode", pe_opcode, 7);
        tick();
        checkOutput("t1_stop_no_valid", pe_valid, 0);
        tick();
        checkOutput("t1_done", done, 1);
        checkOutput("t1_not_busy", busy, 0);
        res_raddr = 6'd5;
        tick();
        checkOutput("t1_result5", res_rdata, {4{32'd3}});
        tick();
        checkOutput("t1_done_held", done, 1);

        // Stall: ADD held with pe_ready low for three cycles
        applyStimulus(2'd0, 6'd0, mkInst(4'd3, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd1, mkInst(4'd10, 6'd0, 4'd0));
        pe_ready = 1'b0;
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_stall_valid", pe_valid, 1);
            checkOutput("t2_stall_opcode", pe_opcode, 1);
            tick();
        end
        pe_ready = 1'b1;
        tick();
        pe_ready = 1'b0;
        checkOutput("t2_after_ready_valid", pe_valid, 0);
        checkOutput("t2_after_ready_busy", busy, 1);
        tick();
        checkOutput("t2_done", done, 1);

        // Stage-2 shift-in, then STORE_RESULT 2 with a colliding stage-1 update
        pe_stage_2_valid = 1'b1;
        pe_stage_2_output = 32'd10; tick();
        pe_stage_2_output = 32'd20; tick();
        pe_stage_2_output = 32'd30; tick();
        pe_stage_2_output = 32'd40; tick();
        pe_stage_2_valid = 1'b0;
        applyStimulus(2'd0, 6'd0, mkInst(4'd9, 6'd2, 4'd0));
        applyStimulus(2'd0, 6'd1, mkInst(4'd10, 6'd0, 4'd0));
        pe_ready = 1'b1;
        pulseStart();
        checkOutput("t3_store_valid", pe_valid, 1);
        pe_stage_1_valid  = 1'b1;
        pe_stage_1_output = {4{32'hdeadbeef}};
        tick();
        pe_stage_1_valid  = 1'b0;
        tick();
        res_raddr = 6'd2;
        tick();
        checkOutput("t3_result2", res_rdata, {32'd10, 32'd20, 32'd30, 32'd40});

        // Stage 1 wins over stage 2 in the same cycle
        pe_stage_1_valid  = 1'b1;
        pe_stage_1_output = {4{32'd7}};
        pe_stage_2_valid  = 1'b1;
        pe_stage_2_output = 32'd99;
        tick();
        pe_stage_1_valid  = 1'b0;
        pe_stage_2_valid  = 1'b0;
        applyStimulus(2'd0, 6'd0, mkInst(4'd9, 6'd3, 4'd0));
        pulseStart();
        tick();
        tick();
        res_raddr = 6'd3;
        tick();
        checkOutput("t3_priority", res_rdata, {4{32'd7}});

        // LOOP count=2 back to ADD
        applyStimulus(2'd0, 6'd0, mkInst(4'd3, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd1, mkInst(4'd11, 6'd0, 4'd2));
        applyStimulus(2'd0, 6'd2, mkInst(4'd10, 6'd0, 4'd0));
`ifdef PE_ISSUE_LOOP_EN
        expectedAdds = 3;
`else
        expectedAdds = 1;
`endif
        addHandshakes = 0;
        pulseStart();
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        checkOutput("t4_loop_done", done, 1);
        checkOutput("t4_add_count", addHandshakes, expectedAdds);
        pe_ready = 1'b0;

        // Reset during a stalled MUL; a RUN-time write must be dropped
        applyStimulus(2'd1, 6'd1, {4{32'h11}});
        applyStimulus(2'd0, 6'd0, mkInst(4'd5, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd1, mkInst(4'd10, 6'd0, 4'd0));
        pulseStart();
        checkOutput("t5_mul_valid", pe_valid, 1);
        checkOutput("t5_mul_opcode", pe_opcode, 3);
        applyStimulus(2'd1, 6'd1, {4{32'hff}});
        checkOutput("t5_still_stalled", pe_valid, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checkOutput("t5_rst_valid", pe_valid, 0);
        checkOutput("t5_rst_opcode", pe_opcode, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_done", done, 0);
        checkOutput("t5_rst_data_a", data_a, 0);
        res_raddr = 6'd5;
        tick();
        checkOutput("t5_mem_retained", res_rdata, {4{32'd3}});

        // Unknown opcode as NOOP, then read back A[1] to see the dropped write
        applyStimulus(2'd0, 6'd0, mkInst(4'd12, 6'd0, 4'd0));
        applyStimulus(2'd0, 6'd1, mkInst(4'd1, 6'd1, 4'd0));
        applyStimulus(2'd0, 6'd2, mkInst(4'd10, 6'd0, 4'd0));
        pulseStart();
        checkOutput("t5_unknown_valid", pe_valid, 0);
        checkOutput("t5_unknown_opcode", pe_opcode, 0);
        tick();
        tick();
        checkOutput("t5_dropped_write", data_a, {4{32'h11}});
        tick();
        checkOutput("t5_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/pe_issue_unit.md
PE_ISSUE_UNIT -- requirements
Module: pe_issue_unit

Interface
REQ-001 SHALL have parameters: LANES, default 4, number of PE lanes.
REQ-002 SHALL have parameters: DATA_LEN, default 32, lane width in bits.
REQ-003 SHALL have parameters: INST_LEN, default 16, instruction width; OPCODE_LEN, default 4; PE_OPCODE_LEN, default 3.
REQ-004 SHALL have parameters: IMEM_DEPTH, default 64, instruction words; DMEM_DEPTH, default 64, words in each of the A, B and result memories.
REQ-005 SHALL have ports (name  direction  width  meaning):
 clk  in  1  sole clock, rising edge
 rstn  in  1  reset, synchronous, active-low
 start  in  1  launch program at pc 0
 prog_we  in  1  program/data load strobe
 prog_sel  in  2  0=inst, 1=A, 2=B, 3=ignored
 prog_addr  in  $clog2(max(IMEM_DEPTH,DMEM_DEPTH))  load address
 prog_wdata  in  DATA_LEN*LANES  load data; instruction uses low INST_LEN bits
 pe_valid  out  1  PE command valid
 pe_ready  in  1  PE accepts command
 pe_opcode  out  PE_OPCODE_LEN  PE command code
 data_a, data_b  out  DATA_LEN*LANES  operand registers
 pe_stage_1_valid  in  1  full-vector result valid
 pe_stage_1_output  in  DATA_LEN*LANES  full-vector result
 pe_stage_2_valid  in  1  scalar result valid
 pe_stage_2_output  in  DATA_LEN  scalar result
 res_raddr  in  $clog2(DMEM_DEPTH)  result readback address
 res_rdata  out  DATA_LEN*LANES  result readback data, 1-cycle latency
 busy  out  1  FSM in RUN
 done  out  1  FSM in HALT

Function
REQ-006 SHALL decode the instruction fields as: opcode [OPCODE_LEN-1:0]; addr [OPCODE_LEN+$clog2(DMEM_DEPTH)-1:OPCODE_LEN]; jump target = low $clog2(IMEM_DEPTH) bits of addr; loop count [INST_LEN-1:INST_LEN-4].
REQ-007 SHALL use these opcodes: NOOP 0, FETCH_A 1, FETCH_B 2, ADD 3, SUB 4, MUL 5, DOTP 6, STORE_TEMP_S1 7, STORE_TEMP_S2 8, STORE_RESULT 9, STOP 10, LOOP 11; codes 12-15 SHALL execute as NOOP.
REQ-008 SHALL implement FSM states IDLE, RUN, HALT: IDLE->RUN on start (pc=0); RUN->HALT on STOP; HALT->RUN on start (pc=0); start SHALL be ignored in RUN.
REQ-009 SHALL, in RUN, complete NOOP, FETCH_A, FETCH_B, LOOP and unknown codes in exactly one cycle each, advancing pc by 1.
REQ-010 SHALL, for FETCH_A/FETCH_B, register A[addr]/B[addr] into data_a/data_b on the same edge that advances pc; the operand is visible the cycle after the fetch.
REQ-011 SHALL drive pe_valid=1 for the PE codes ADD..STORE_RESULT, with pe_opcode = opcode-2 (ADD=1 .. STORE_RESULT=7).
REQ-012 SHALL hold pe_valid, pe_opcode and pc stable until pe_ready=1; pc SHALL advance on the edge where pe_valid&&pe_ready.
REQ-013 SHALL drive pe_valid=0 and pe_opcode=0 in IDLE, in HALT and for non-PE codes.
REQ-014 SHALL collect results into an internal register: pe_stage_1_valid loads the full vector; otherwise pe_stage_2_valid shifts the register up one lane and writes pe_stage_2_output into lane 0; stage 1 SHALL win when both are valid.
REQ-015 SHALL, on STORE_RESULT handshake, write the pre-edge result register to result[addr]; a same-cycle result update SHALL NOT affect the stored value.
REQ-016 SHALL wrap pc from IMEM_DEPTH-1 to 0.
REQ-017 SHALL keep pc unchanged in HALT; done SHALL remain 1 until start.
REQ-018 SHALL accept prog_we writes only in IDLE and HALT; writes in RUN SHALL be dropped; out-of-range addresses SHALL be dropped.
REQ-019 SHALL make res_rdata = result[res_raddr] one cycle after res_raddr is presented, in any state.

Reset
REQ-020 SHALL, with rstn=0 at a clock edge, set FSM=IDLE and clear pc, loop counter, data_a, data_b, result register, pe_valid, pe_opcode, busy and done; this SHALL apply mid-program and mid-stall.
REQ-021 SHALL retain memory contents through reset; res_rdata after reset SHALL reflect the memory on the first read.

Configuration
REQ-022 SHALL support macro PE_ISSUE_LOOP_EN; when defined, LOOP SHALL execute as follows:
 - counter=0 and count>0: load count, jump to target.
 - counter>1: decrement counter, jump to target.
 - counter=1: clear counter, pc+1.
 - count=0 with counter=0: pc+1.
 - The body thus runs count+1 times; loops SHALL NOT nest.
REQ-023 SHALL, when PE_ISSUE_LOOP_EN is undefined, execute LOOP as NOOP and omit the loop counter.

Verification
REQ-024 Load A[0]=4x1, B[0]=4x2; program FETCH_A 0, FETCH_B 0, ADD, STORE_RESULT 5, STOP; pe_ready=1; model returns stage-1 vector 4x3 -> result[5]=4x3, done=1, pe_opcode sequence 1,7.
REQ-025 Hold pe_ready=0 for 3 cycles during ADD -> pe_valid and pe_opcode=1 held, pc frozen, then advance on ready.
REQ-026 Apply stage-2 values 10,20,30,40 on consecutive cycles, then STORE_RESULT 2 -> result[2] lanes 3..0 = 10,20,30,40.
REQ-027 With PE_ISSUE_LOOP_EN: body ADD with LOOP count=2 back to ADD -> exactly 3 ADD handshakes; without the macro -> 1.
REQ-028 Assert rstn=0 during a stalled MUL -> next cycle pe_valid=0, busy=0, pc=0; prog_we in RUN leaves memory unchanged.
